reveal_sequencer: RTL and testbench

Flood-fill reveal controller for the 8x8 minesweeper board. It accepts one "step on cell (x,y)" request at a time and sequences read and write accesses to the external board cell store. It opens the stepped cell and, when that cell has zero adjacent mines, breadth-first opens every connected zero region plus its numbered border. It sits between the keypad/game FSM and the cell store, and reports mine hit, already-open, or number of cells opened.

---
 rtl/minesweeper_pkg.sv | 47 ++++
 rtl/reveal_sequencer_if.sv | 36 +++
 rtl/reveal_sequencer_fifo.sv | 59 +++++
 rtl/reveal_sequencer.sv | 172 +++++++++++++++++
 tb/tb_reveal_sequencer.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg
//   Shared types and constants for the 8x8 minesweeper board logic.
//   - BOARD_DIM, CELL_AW, CNT_W : board size, cell address width, count width
//   - result_t                  : outcome reported by the reveal sequencer
//   - rs_state_t                : reveal sequencer FSM states
//   - cell_rd_t                 : cell-store read word {mine, opened, count}
//   - NB_DX / NB_DY             : neighbour offsets, order NW N NE W E SW S SE
package minesweeper_pkg;

   localparam int BOARD_DIM = 8;
   localparam int COORD_W   = 3;
   localparam int CELL_AW   = 6;
   localparam int CNT_W     = 7;

   typedef enum logic [1:0] {
      RES_OPENED  = 2'd0,
      RES_MINE    = 2'd1,
      RES_ALREADY = 2'd2
   } result_t;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CHK_SEED = 3'd1,
      POP      = 3'd2,
      NB_ISSUE = 3'd3,
      NB_CHK   = 3'd4,
      DONE     = 3'd5
   } rs_state_t;

   typedef struct packed {
      logic       mine;
      logic       opened;
      logic [3:0] count;
   } cell_rd_t;

   // Signed 4-bit so that x-1 / x+1 land on -1 / 8 and can be rejected by bit 3.
   localparam logic signed [3:0] NB_DX [8] = '{-4'sd1, 4'sd0, 4'sd1, -4'sd1,
                                               4'sd1, -4'sd1, 4'sd0, 4'sd1};
   localparam logic signed [3:0] NB_DY [8] = '{-4'sd1, -4'sd1, -4'sd1, 4'sd0,
                                               4'sd0, 4'sd1, 4'sd1, 4'sd1};

   function automatic logic [CELL_AW-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                    input logic [COORD_W-1:0] y);
      return {y, x};
   endfunction

endpackage

// File: rtl/reveal_sequencer_if.sv
// reveal_sequencer_if
//   Bundles the request/response handshake with the game FSM and the
//   cell-store read/write bus.
//   - master : the reveal sequencer (drives strobes, addresses, status)
//   - slave  : the environment (game FSM + cell store)
interface reveal_sequencer_if;
   import minesweeper_pkg::*;

   logic                  abort;
   logic                  req_valid;
   logic                  req_ready;
   logic [COORD_W-1:0]    req_x;
   logic [COORD_W-1:0]    req_y;
   logic                  cell_rd_en;
   logic [CELL_AW-1:0]    cell_rd_addr;
   cell_rd_t              cell_rd_data;
   logic                  cell_wr_en;
   logic [CELL_AW-1:0]    cell_wr_addr;
   logic                  done;
   result_t               result;
   logic [CNT_W-1:0]      opened_cnt;
   logic                  busy;

   modport master (
      input  abort, req_valid, req_x, req_y, cell_rd_data,
      output req_ready, cell_rd_en, cell_rd_addr, cell_wr_en, cell_wr_addr,
             done, result, opened_cnt, busy
   );

   modport slave (
      output abort, req_valid, req_x, req_y, cell_rd_data,
      input  req_ready, cell_rd_en, cell_rd_addr, cell_wr_en, cell_wr_addr,
             done, result, opened_cnt, busy
   );

endinterface

// File: rtl/reveal_sequencer_fifo.sv
// reveal_fifo
//   64 x 6-bit register FIFO holding zero-count cells still to be expanded.
//   - CLK, RST_N : clock, async active-low reset (to empty)
//   - flush      : synchronous empty
//   - push, din  : enqueue
//   - pop, dout  : dequeue, dout is the combinational head
//   - empty, full: occupancy flags (7-bit occupancy, 0..64)
module reveal_fifo
   import minesweeper_pkg::*;
(
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               flush,
   input  logic               push,
   input  logic               pop,
   input  logic [CELL_AW-1:0] din,
   output logic [CELL_AW-1:0] dout,
   output logic               empty,
   output logic               full
);

   localparam int DEPTH = 64;

   logic [CELL_AW-1:0] mem [DEPTH];
   logic [5:0]         wr_ptr;
   logic [5:0]         rd_ptr;
   logic [6:0]         occ;

   // Storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge CLK)
      if (push && !full) mem[wr_ptr] <= din;

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 6'd1;
         if (pop)  rd_ptr <= rd_ptr + 6'd1;
         case ({push, pop})
            2'b10:   occ <= occ + 7'd1;
            2'b01:   occ <= occ - 7'd1;
            default: ;
         endcase
      end

   assign dout  = mem[rd_ptr];
   assign empty = (occ == 7'd0);
   assign full  = (occ == 7'd64);

   // Each cell is pushed at most once, so this can only fire on a logic bug.
   a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N) !(push && full));

endmodule

// File: rtl/reveal_sequencer.sv
// reveal_sequencer
//   Flood-fill reveal controller for the 8x8 board. Opens the stepped cell
//   and, for a zero-count cell, breadth-first opens the connected zero region
//   plus its numbered border via the external cell store.
//   - CLK, RST_N : clock, async active-low reset
//   - bus        : reveal_sequencer_if.master
//                  abort/req_* in, req_ready out      (game FSM side)
//                  cell_rd_*/cell_wr_* (cell store, 1-cycle read latency)
//                  done/result/opened_cnt/busy status
module reveal_sequencer
   import minesweeper_pkg::*;
(
   input  logic CLK,
   input  logic RST_N,
   reveal_sequencer_if.master bus
);

   rs_state_t          state, state_nxt;
   logic [CELL_AW-1:0] seed;
   logic [CELL_AW-1:0] cur;
   logic [2:0]         nb_idx;
   result_t            result_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               rd_en, wr_en, push, pop;
   logic [CELL_AW-1:0] rd_addr, wr_addr;
   logic [CELL_AW-1:0] fifo_dout;
   logic               fifo_empty, fifo_full;

   cell_rd_t           rd;
   logic               take_cell;
   logic signed [3:0]  nb_x, nb_y;
   logic               nb_in, nb_last;
   logic [CELL_AW-1:0] nb_addr;

   assign rd        = bus.cell_rd_data;
   assign take_cell = !rd.opened && !rd.mine;

   // Neighbour of cur selected by nb_idx; bit 3 set means -1 or 8 (off-board).
   assign nb_x    = $signed({1'b0, cur[2:0]}) + NB_DX[nb_idx];
   assign nb_y    = $signed({1'b0, cur[5:3]}) + NB_DY[nb_idx];
   assign nb_in   = !nb_x[3] && !nb_y[3];
   assign nb_addr = {nb_y[2:0], nb_x[2:0]};
   assign nb_last = (nb_idx == 3'd7);

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_addr   = '0;
      wr_en     = 1'b0;
      wr_addr   = '0;
      push      = 1'b0;
      pop       = 1'b0;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:
               if (bus.req_valid) begin
                  rd_en     = 1'b1;
                  rd_addr   = cell_addr(bus.req_x, bus.req_y);
                  state_nxt = CHK_SEED;
               end
            CHK_SEED:
               if (rd.opened || rd.mine) begin
                  state_nxt = DONE;
               end else begin
                  wr_en     = 1'b1;
                  wr_addr   = seed;
                  push      = (rd.count == 4'd0);
                  state_nxt = POP;
               end
            POP:
               if (fifo_empty) begin
                  state_nxt = DONE;
               end else begin
                  pop       = 1'b1;
                  state_nxt = NB_ISSUE;
               end
            NB_ISSUE:
               if (nb_in) begin
                  rd_en     = 1'b1;
                  rd_addr   = nb_addr;
                  state_nxt = NB_CHK;
               end else if (nb_last) begin
                  state_nxt = POP;
               end
            NB_CHK: begin
               // Pushing only when marking opened guarantees one push per cell.
               if (take_cell) begin
                  wr_en   = 1'b1;
                  wr_addr = nb_addr;
                  push    = (rd.count == 4'd0);
               end
               state_nxt = nb_last ? POP : NB_ISSUE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         seed     <= '0;
         cur      <= '0;
         nb_idx   <= '0;
         result_q <= RES_OPENED;
         cnt_q    <= '0;
      end else if (!bus.abort) begin
         case (state)
            IDLE:
               if (bus.req_valid) begin
                  seed  <= cell_addr(bus.req_x, bus.req_y);
                  cnt_q <= '0;
               end
            CHK_SEED:
               if (rd.opened) begin
                  result_q <= RES_ALREADY;
                  cnt_q    <= '0;
               end else if (rd.mine) begin
                  result_q <= RES_MINE;
                  cnt_q    <= '0;
               end else begin
                  cnt_q    <= 7'd1;
               end
            POP:
               // result is only published on the way into DONE so an abort
               // leaves the previous outcome visible.
               if (fifo_empty) begin
                  result_q <= RES_OPENED;
               end else begin
                  cur    <= fifo_dout;
                  nb_idx <= '0;
               end
            NB_ISSUE:
               if (!nb_in && !nb_last) nb_idx <= nb_idx + 3'd1;
            NB_CHK: begin
               if (take_cell) cnt_q  <= cnt_q + 7'd1;
               if (!nb_last)  nb_idx <= nb_idx + 3'd1;
            end
            default: ;
         endcase
      end

   reveal_fifo u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .flush (bus.abort),
      .push  (push),
      .pop   (pop),
      .din   (wr_addr),
      .dout  (fifo_dout),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign bus.req_ready    = (state == IDLE) && !bus.abort;
   assign bus.busy         = (state != IDLE);
   assign bus.done         = (state == DONE) && !bus.abort;
   assign bus.result       = result_q;
   assign bus.opened_cnt   = cnt_q;
   assign bus.cell_rd_en   = rd_en;
   assign bus.cell_rd_addr = rd_addr;
   assign bus.cell_wr_en   = wr_en;
   assign bus.cell_wr_addr = wr_addr;

endmodule

// File: tb/tb_reveal_sequencer.sv
// tb_reveal_sequencer
//   Directed bench for reveal_sequencer with a behavioural cell store
//   (mine map + opened bits, counts derived from the mine map).
module tb_reveal_sequencer;
   import minesweeper_pkg::*;

   logic CLK;
   logic RST_N;
   logic clr_open;

   reveal_sequencer_if bus ();

   reveal_sequencer dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic mine_map   [64];
   logic opened_map [64];
   int   n_chk, n_err;
   int   wr_cnt, wr0_cnt, rd_cnt, done_cnt, full_seen;

   function automatic logic [3:0] cnt_of(input int a);
      int x, y, n;
      x = a % 8;
      y = a / 8;
      n = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < 8 && y + dy >= 0 && y + dy < 8)
               n += int'(mine_map[(y + dy) * 8 + x + dx]);
      return 4'(n);
   endfunction

   // Cell store: 1-cycle read latency, write visible to reads issued next cycle.
   always @(posedge CLK) begin
      if (clr_open) begin
         for (int i = 0; i < 64; i++) opened_map[i] <= 1'b0;
      end else if (bus.cell_wr_en) begin
         opened_map[bus.cell_wr_addr] <= 1'b1;
      end
      if (bus.cell_rd_en)
         bus.cell_rd_data <= {mine_map[bus.cell_rd_addr], opened_map[bus.cell_rd_addr],
                              cnt_of(int'(bus.cell_rd_addr))};
      if (bus.cell_wr_en)                                wr_cnt    <= wr_cnt + 1;
      if (bus.cell_wr_en && bus.cell_wr_addr == 6'd0)    wr0_cnt   <= wr0_cnt + 1;
      if (bus.cell_rd_en)                                rd_cnt    <= rd_cnt + 1;
      if (bus.done)                                      done_cnt  <= done_cnt + 1;
      if (dut.u_fifo.full)                               full_seen <= full_seen + 1;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic setup_board();
      for (int i = 0; i < 64; i++) mine_map[i] = 1'b0;
      clr_open = 1'b1;
      @(posedge CLK);
      #1 clr_open = 1'b0;
   endtask

   // Present a request at cycle 0; lat is the cycle index at which done is seen.
   task automatic do_req(input int x, input int y, output int lat);
      @(negedge CLK);
      chk("ready_idle", int'(bus.req_ready), 1);
      bus.req_valid = 1'b1;
      bus.req_x     = 3'(x);
      bus.req_y     = 3'(y);
      @(posedge CLK);
      #1 bus.req_valid = 1'b0;
      lat = -1;
      for (int k = 1; k <= 3000 && lat < 0; k++) begin
         @(negedge CLK);
         if (k == 1) chk("ready_low", int'(bus.req_ready), 0);
         if (bus.done) lat = k;
      end
      if (lat < 0) chk("done_timeout", 0, 1);
   endtask

   task automatic start_req(input int x, input int y);
      @(negedge CLK);
      bus.req_valid = 1'b1;
      bus.req_x     = 3'(x);
      bus.req_y     = 3'(y);
      @(posedge CLK);
      #1 bus.req_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, w0, r0, z0, d0, f0, n;
      n_chk = 0; n_err = 0;
      wr_cnt = 0; wr0_cnt = 0; rd_cnt = 0; done_cnt = 0; full_seen = 0;
      clr_open = 1'b0;
      for (int i = 0; i < 64; i++) mine_map[i] = 1'b0;
      RST_N = 1'b0;
      bus.abort = 1'b0; bus.req_valid = 1'b0; bus.req_x = '0; bus.req_y = '0;
      #12;
      chk("rst_ready",  int'(bus.req_ready), 1);
      chk("rst_busy",   int'(bus.busy), 0);
      chk("rst_rd_en",  int'(bus.cell_rd_en), 0);
      chk("rst_wr_en",  int'(bus.cell_wr_en), 0);
      chk("rst_done",   int'(bus.done), 0);
      chk("rst_result", int'(bus.result), 0);
      chk("rst_cnt",    int'(bus.opened_cnt), 0);
      chk("rst_addrs",  int'(bus.cell_rd_addr) + int'(bus.cell_wr_addr), 0);
      @(negedge CLK) RST_N = 1'b1;

      // Mine hit at (3,4).
      setup_board();
      mine_map[35] = 1'b1;
      w0 = wr_cnt;
      do_req(3, 4, lat);
      chk("mine_lat", lat, 2);
      chk("mine_result", int'(bus.result), 1);
      chk("mine_cnt", int'(bus.opened_cnt), 0);
      chk("mine_writes", wr_cnt - w0, 0);

      // Numbered seed (1,0) with a mine at (2,0), then repeat.
      setup_board();
      mine_map[2] = 1'b1;
      w0 = wr_cnt;
      do_req(1, 0, lat);
      chk("num_lat", lat, 3);
      chk("num_result", int'(bus.result), 0);
      chk("num_cnt", int'(bus.opened_cnt), 1);
      chk("num_writes", wr_cnt - w0, 1);
      chk("num_open1", int'(opened_map[1]), 1);
      do_req(1, 0, lat);
      chk("again_lat", lat, 2);
      chk("again_result", int'(bus.result), 2);
      chk("again_cnt", int'(bus.opened_cnt), 0);

      // All-clear board from (0,0): 64 pops, 4*3+24*5+36*8+1 reads.
      setup_board();
      w0 = wr_cnt; r0 = rd_cnt;
      do_req(0, 0, lat);
      chk("clear_lat", lat, 999);
      chk("clear_result", int'(bus.result), 0);
      chk("clear_cnt", int'(bus.opened_cnt), 64);
      chk("clear_reads", rd_cnt - r0, 421);
      chk("clear_writes", wr_cnt - w0, 64);

      // Single mine at (0,0), request (7,7).
      setup_board();
      mine_map[0] = 1'b1;
      w0 = wr_cnt; z0 = wr0_cnt; f0 = full_seen;
      do_req(7, 7, lat);
      chk("corner_result", int'(bus.result), 0);
      chk("corner_cnt", int'(bus.opened_cnt), 63);
      chk("corner_writes", wr_cnt - w0, 63);
      chk("corner_addr0", wr0_cnt - z0, 0);
      chk("corner_full", full_seen - f0, 0);
      n = 0;
      for (int i = 1; i < 64; i++) n += int'(opened_map[i]);
      chk("corner_opened", n, 63);

      // Abort three cycles into a fill with a competing request.
      setup_board();
      d0 = done_cnt;
      start_req(0, 0);
      @(posedge CLK);
      @(posedge CLK);
      #1;
      bus.abort = 1'b1;
      bus.req_valid = 1'b1; bus.req_x = 3'd5; bus.req_y = 3'd5;
      @(negedge CLK);
      chk("abort_ready", int'(bus.req_ready), 0);
      @(posedge CLK);
      #1;
      bus.abort = 1'b0; bus.req_valid = 1'b0;
      chk("abort_busy", int'(bus.busy), 0);
      chk("abort_fifo_empty", int'(dut.u_fifo.empty), 1);
      repeat (3) @(negedge CLK);
      chk("abort_busy_late", int'(bus.busy), 0);
      chk("abort_no_done", done_cnt - d0, 0);
      do_req(7, 7, lat);
      chk("post_abort_result", int'(bus.result), 0);
      chk("post_abort_cnt", int'(bus.opened_cnt), 63);

      // Reset mid-fill, with a non-zero result held beforehand.
      setup_board();
      mine_map[9] = 1'b1;
      do_req(1, 1, lat);
      chk("pre_rst_result", int'(bus.result), 1);
      setup_board();
      start_req(0, 0);
      repeat (20) @(posedge CLK);
      #3 RST_N = 1'b0;
      #1;
      chk("mrst_busy",   int'(bus.busy), 0);
      chk("mrst_ready",  int'(bus.req_ready), 1);
      chk("mrst_rd_en",  int'(bus.cell_rd_en), 0);
      chk("mrst_wr_en",  int'(bus.cell_wr_en), 0);
      chk("mrst_done",   int'(bus.done), 0);
      chk("mrst_result", int'(bus.result), 0);
      chk("mrst_cnt",    int'(bus.opened_cnt), 0);
      chk("mrst_fifo",   int'(dut.u_fifo.empty), 1);
      @(negedge CLK) RST_N = 1'b1;
      setup_board();
      do_req(0, 0, lat);
      chk("after_rst_lat", lat, 999);
      chk("after_rst_cnt", int'(bus.opened_cnt), 64);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
